// File: rtl/mem_cmd_responder_pkg.sv
// Shared definitions for the tester command interface: command codes,
// default bus widths and the responder state encoding. The tester controller
// imports the same package so both ends agree on the codes.
package mem_cmd_responder_pkg;

    localparam int PKG_ADDR_W = 16;
    localparam int PKG_DATA_W = 8;

    localparam logic [7:0] PKG_CMD_RD = 8'h00;
    localparam logic [7:0] PKG_CMD_WR = 8'h01;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_WR_WAIT  = 3'd1;
    localparam state_t S_WR_MEM   = 3'd2;
    localparam state_t S_RD_ISSUE = 3'd3;
    localparam state_t S_RD_WAIT  = 3'd4;
    localparam state_t S_RD_SEND  = 3'd5;
    localparam state_t S_DONE     = 3'd6;
    localparam state_t S_ERR      = 3'd7;

endpackage

// File: rtl/mem_cmd_responder.sv
// Processor-side responder for the tester command interface. Accepts a
// read or write command over an inclusive address range and moves bytes
// between the UART streams and an external synchronous RAM, one byte at a
// time in ascending address order.
module mem_cmd_responder
    import mem_cmd_responder_pkg::*;
#(
    parameter int         ADDR_W = PKG_ADDR_W,
    parameter int         DATA_W = PKG_DATA_W,
    parameter logic [7:0] CMD_RD = PKG_CMD_RD,
    parameter logic [7:0] CMD_WR = PKG_CMD_WR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_start,
    input  logic [7:0]        i_command,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_busy,
    output logic              o_cmd_err,
    output logic              o_rx_done,
    output logic              o_tx_done,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_rx_ready,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_curAddr;
    logic [ADDR_W-1:0]   r_endAddr;
    logic                r_busy;
    logic                r_cmdErr;
    logic                r_rxDone;
    logic                r_txDone;
    logic                r_rxReady;
    logic                r_txValid;
    logic [DATA_W-1:0]   r_txData;
    logic [ADDR_W-1:0]   r_memAddr;
    logic                r_memWe;
    logic [DATA_W-1:0]   r_memWdata;

    logic [ADDR_W-1:0]   w_curNext;
    logic                w_curIsEnd;
    logic                w_cmdBad;

    // The end test is done on the current address before incrementing, so an
    // all-ones end address finishes without the counter wrapping to zero.
    assign w_curNext  = r_curAddr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_curIsEnd = (r_curAddr == r_endAddr);
    assign w_cmdBad   = (i_end_addr < i_start_addr) ||
                        ((i_command != CMD_RD) && (i_command != CMD_WR));

    // Command FSM: every output is a register updated here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_curAddr  <= '0;
            r_endAddr  <= '0;
            r_busy     <= 1'b0;
            r_cmdErr   <= 1'b0;
            r_rxDone   <= 1'b0;
            r_txDone   <= 1'b0;
            r_rxReady  <= 1'b0;
            r_txValid  <= 1'b0;
            r_txData   <= '0;
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
        end else begin
            r_cmdErr <= 1'b0;
            r_rxDone <= 1'b0;
            r_txDone <= 1'b0;
            r_memWe  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_start) begin
                        r_curAddr <= i_start_addr;
                        r_endAddr <= i_end_addr;
                        r_busy    <= 1'b1;
                        if (w_cmdBad) begin
                            r_cmdErr <= 1'b1;
                            r_state  <= S_ERR;
                        end else if (i_command == CMD_WR) begin
                            r_rxReady <= 1'b1;
                            r_state   <= S_WR_WAIT;
                        end else begin
                            // Present the first read address while in RD_ISSUE so
                            // the RAM data is available during RD_WAIT.
                            r_memAddr <= i_start_addr;
                            r_state   <= S_RD_ISSUE;
                        end
                    end
                end
                S_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_WR_WAIT: begin
                    if (i_rx_valid && r_rxReady) begin
                        r_rxReady  <= 1'b0;
                        r_memAddr  <= r_curAddr;
                        r_memWdata <= i_rx_data;
                        r_memWe    <= 1'b1;
                        r_state    <= S_WR_MEM;
                    end
                end
                S_WR_MEM: begin
                    if (w_curIsEnd) begin
                        r_rxDone <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_curAddr <= w_curNext;
                        r_rxReady <= 1'b1;
                        r_state   <= S_WR_WAIT;
                    end
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_txData  <= i_mem_rdata;
                    r_txValid <= 1'b1;
                    r_state   <= S_RD_SEND;
                end
                S_RD_SEND: begin
                    if (i_tx_ready) begin
                        r_txValid <= 1'b0;
                        if (w_curIsEnd) begin
                            r_txDone <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_curAddr <= w_curNext;
                            r_memAddr <= w_curNext;
                            r_state   <= S_RD_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_rxReady <= 1'b0;
                    r_txValid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_cmd_err   = r_cmdErr;
    assign o_rx_done   = r_rxDone;
    assign o_tx_done   = r_txDone;
    assign o_rx_ready  = r_rxReady;
    assign o_tx_valid  = r_txValid;
    assign o_tx_data   = r_txData;
    assign o_mem_addr  = r_memAddr;
    assign o_mem_we    = r_memWe;
    assign o_mem_wdata = r_memWdata;

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench for mem_cmd_responder with a behavioural synchronous RAM
// and a negedge monitor that records RAM writes, TX handshakes and pulses.
module tb_mem_cmd_responder;

    logic        clk;
    logic        rst;
    logic        cmd_start;
    logic [7:0]  command;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic        busy;
    logic        cmd_err;
    logic        rx_done;
    logic        tx_done;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  ram [0:65535];
    logic [15:0] wrAddrQ [$];
    logic [7:0]  wrDataQ [$];
    logic [7:0]  txQ [$];
    int          rxDoneCnt  = 0;
    int          txDoneCnt  = 0;
    int          errCnt     = 0;
    int          rxReadyCnt = 0;
    int          busyCnt    = 0;
    int          stabErr    = 0;
    int          zeroSeen   = 0;
    bit          watchZero  = 0;
    bit          prevHold   = 0;
    logic [7:0]  prevData   = 8'h00;

    mem_cmd_responder dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_start  (cmd_start),
        .i_command    (command),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .o_busy       (busy),
        .o_cmd_err    (cmd_err),
        .o_rx_done    (rx_done),
        .o_tx_done    (tx_done),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_rx_ready   (rx_ready),
        .o_tx_valid   (tx_valid),
        .o_tx_data    (tx_data),
        .i_tx_ready   (tx_ready),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External synchronous RAM: write-enable store, one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Mid-cycle monitor recording everything the checks later inspect
    always @(negedge clk) begin
        if (mem_we) begin
            wrAddrQ.push_back(mem_addr);
            wrDataQ.push_back(mem_wdata);
        end
        if (tx_valid && tx_ready) txQ.push_back(tx_data);
        if (rx_done)  rxDoneCnt++;
        if (tx_done)  txDoneCnt++;
        if (cmd_err)  errCnt++;
        if (rx_ready) rxReadyCnt++;
        if (busy)     busyCnt++;
        if (prevHold && (!tx_valid || tx_data !== prevData)) stabErr++;
        prevHold = tx_valid && !tx_ready && !rst;
        prevData = tx_data;
        if (watchZero && mem_addr == 16'h0000) zeroSeen++;
    end

    task automatic sendCmd(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        @(posedge clk); #1;
        cmd_start  = 1'b1;
        command    = c;
        start_addr = s;
        end_addr   = e;
        @(posedge clk); #1;
        cmd_start  = 1'b0;
    endtask

    task automatic sendRx(input logic [7:0] d, output bit ok);
        ok = 0;
        rx_valid = 1'b1;
        rx_data  = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic recvTx(input int stall, output bit ok);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_valid) begin
                ok = 1;
                break;
            end
        end
        repeat (stall) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic waitIdle(output bit ok);
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs [10];
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = '{7'b0 + busy, 7'b0 + cmd_err, 7'b0 + rx_done, 7'b0 + tx_done, 7'b0 + rx_ready,
                7'b0 + tx_valid, 7'b0 + mem_we, mem_addr[7:0] | mem_addr[15:8], mem_wdata, tx_data};
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (obs[i] !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL reset_out%0d actual=%h required=00", i, obs[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic [7:0] bytes [3] = '{8'hA5, 8'h5A, 8'h3C};
        int wBase = wrAddrQ.size();
        int rBase = rxDoneCnt;
        bit ok;
        sendCmd(8'h01, 16'h0010, 16'h0012);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL wr_busy actual=%b required=1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            sendRx(bytes[i], ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("[TB] FAIL wr_rx_timeout byte%0d actual=timeout required=accept", i);
            end
        end
        waitIdle(ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL wr_idle actual=busy required=idle");
        end
        compared++;
        if (wrAddrQ.size() - wBase != 3) begin
            mismatched++;
            $display("[TB] FAIL wr_count actual=%0d required=3", wrAddrQ.size() - wBase);
        end else begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (wrAddrQ[wBase+i] !== 16'h0010 + 16'(i) || wrDataQ[wBase+i] !== bytes[i]) begin
                    mismatched++;
                    $display("[TB] FAIL wr_byte%0d actual=%h:%h required=%h:%h", i,
                             wrAddrQ[wBase+i], wrDataQ[wBase+i], 16'h0010 + 16'(i), bytes[i]);
                end
            end
        end
        compared++;
        if (rxDoneCnt - rBase != 1) begin
            mismatched++;
            $display("[TB] FAIL wr_rx_done actual=%0d required=1", rxDoneCnt - rBase);
        end
    endtask

    task automatic test_read();
        logic [7:0] bytes [3] = '{8'hA5, 8'h5A, 8'h3C};
        int tBase = txQ.size();
        int dBase = txDoneCnt;
        int sBase = stabErr;
        bit ok;
        sendCmd(8'h00, 16'h0010, 16'h0012);
        for (int i = 0; i < 3; i++) begin
            recvTx(5, ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("[TB] FAIL rd_tx_timeout byte%0d actual=timeout required=valid", i);
            end
        end
        waitIdle(ok);
        repeat (2) @(negedge clk);
        compared++;
        if (txQ.size() - tBase != 3) begin
            mismatched++;
            $display("[TB] FAIL rd_count actual=%0d required=3", txQ.size() - tBase);
        end else begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (txQ[tBase+i] !== bytes[i]) begin
                    mismatched++;
                    $display("[TB] FAIL rd_byte%0d actual=%h required=%h", i, txQ[tBase+i], bytes[i]);
                end
            end
        end
        compared++;
        if (txDoneCnt - dBase != 1) begin
            mismatched++;
            $display("[TB] FAIL rd_tx_done actual=%0d required=1", txDoneCnt - dBase);
        end
        compared++;
        if (stabErr - sBase != 0) begin
            mismatched++;
            $display("[TB] FAIL rd_stable actual=%0d required=0", stabErr - sBase);
        end
    endtask

    task automatic test_range_err();
        int eBase = errCnt;
        int wBase = wrAddrQ.size();
        int rBase = rxReadyCnt;
        int bBase = busyCnt;
        sendCmd(8'h01, 16'h0020, 16'h001F);
        repeat (4) @(negedge clk);
        compared++;
        if (errCnt - eBase != 1) begin
            mismatched++;
            $display("[TB] FAIL range_err_pulse actual=%0d required=1", errCnt - eBase);
        end
        compared++;
        if (wrAddrQ.size() - wBase != 0 || rxReadyCnt - rBase != 0) begin
            mismatched++;
            $display("[TB] FAIL range_err_activity actual=we%0d/rdy%0d required=0/0",
                     wrAddrQ.size() - wBase, rxReadyCnt - rBase);
        end
        compared++;
        if (busyCnt - bBase != 1) begin
            mismatched++;
            $display("[TB] FAIL range_err_busy actual=%0d required=1", busyCnt - bBase);
        end
    endtask

    task automatic test_bad_cmd();
        int eBase = errCnt;
        int rBase = rxReadyCnt;
        int wBase = wrAddrQ.size();
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        sendCmd(8'h07, 16'h0030, 16'h0031);
        repeat (5) @(negedge clk);
        compared++;
        if (errCnt - eBase != 1) begin
            mismatched++;
            $display("[TB] FAIL bad_cmd_err actual=%0d required=1", errCnt - eBase);
        end
        compared++;
        if (rxReadyCnt - rBase != 0 || wrAddrQ.size() - wBase != 0) begin
            mismatched++;
            $display("[TB] FAIL bad_cmd_rx actual=rdy%0d/we%0d required=0/0",
                     rxReadyCnt - rBase, wrAddrQ.size() - wBase);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bad_cmd_idle actual=%b required=0", busy);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_top_addr();
        int wBase = wrAddrQ.size();
        int tBase = txQ.size();
        int dBase = txDoneCnt;
        int zBase = zeroSeen;
        bit ok;
        sendCmd(8'h01, 16'hFFFF, 16'hFFFF);
        sendRx(8'h77, ok);
        waitIdle(ok);
        compared++;
        if (wrAddrQ.size() - wBase != 1 || wrAddrQ[wBase] !== 16'hFFFF || wrDataQ[wBase] !== 8'h77) begin
            mismatched++;
            $display("[TB] FAIL top_write actual=n%0d required=n1@FFFF:77", wrAddrQ.size() - wBase);
        end
        sendCmd(8'h00, 16'hFFFF, 16'hFFFF);
        watchZero = 1;
        recvTx(1, ok);
        waitIdle(ok);
        repeat (4) @(negedge clk);
        watchZero = 0;
        compared++;
        if (txQ.size() - tBase != 1 || txQ[tBase] !== 8'h77) begin
            mismatched++;
            $display("[TB] FAIL top_read actual=n%0d required=n1:77", txQ.size() - tBase);
        end
        compared++;
        if (txDoneCnt - dBase != 1) begin
            mismatched++;
            $display("[TB] FAIL top_tx_done actual=%0d required=1", txDoneCnt - dBase);
        end
        compared++;
        if (zeroSeen - zBase != 0) begin
            mismatched++;
            $display("[TB] FAIL top_no_wrap actual=%0d required=0", zeroSeen - zBase);
        end
    endtask

    task automatic test_reset_mid();
        int wBase = wrAddrQ.size();
        int rBase = rxDoneCnt;
        bit ok;
        sendCmd(8'h01, 16'h0040, 16'h0043);
        sendRx(8'hE1, ok);
        sendRx(8'hE2, ok);
        compared++;
        if (mem_we !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_we_before actual=%b required=1", mem_we);
        end
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({busy, cmd_err, rx_done, tx_done, rx_ready, tx_valid, mem_we} !== 7'b0 ||
            mem_addr !== 16'h0 || mem_wdata !== 8'h0 || tx_data !== 8'h0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_out actual=%b/%h/%h/%h required=0",
                     {busy, cmd_err, rx_done, tx_done, rx_ready, tx_valid, mem_we},
                     mem_addr, mem_wdata, tx_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (wrAddrQ.size() - wBase != 1 || rxDoneCnt - rBase != 0) begin
            mismatched++;
            $display("[TB] FAIL mid_abort actual=we%0d/done%0d required=1/0",
                     wrAddrQ.size() - wBase, rxDoneCnt - rBase);
        end
        wBase = wrAddrQ.size();
        sendCmd(8'h01, 16'h0050, 16'h0050);
        sendRx(8'hC3, ok);
        waitIdle(ok);
        compared++;
        if (wrAddrQ.size() - wBase != 1 || wrAddrQ[wBase] !== 16'h0050 ||
            wrDataQ[wBase] !== 8'hC3 || rxDoneCnt - rBase != 1) begin
            mismatched++;
            $display("[TB] FAIL mid_next_cmd actual=n%0d/done%0d required=n1@0050:C3/1",
                     wrAddrQ.size() - wBase, rxDoneCnt - rBase);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_start  = 1'b0;
        command    = 8'h00;
        start_addr = 16'h0;
        end_addr   = 16'h0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tx_ready   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_range_err();
        test_bad_cmd();
        test_top_addr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
